combination_fsm: RTL

//  Consumer of the FM*WM product memory filled by the transformation stage.

---
 rtl/combination_if.sv | 36 +++
 rtl/combination_fsm.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/combination_if.sv
// Bus bundle for combination_fsm: run control, COO and product memory read ports,
// and the aggregated-row valid/ready output stream.
interface combination_if #(
  parameter int unsigned WEIGHT_COLS           = 3,
  parameter int unsigned DOT_WIDTH             = 16,
  parameter int unsigned COUNTER_EDGE_WIDTH    = 3,
  parameter int unsigned COUNTER_FEATURE_WIDTH = 3
);
  logic                               start;
  logic                               busy;
  logic                               done;
  logic                               err;
  logic                               coo_read_en;
  logic [COUNTER_EDGE_WIDTH-1:0]      coo_read_addr;
  logic [COUNTER_FEATURE_WIDTH-1:0]   coo_src;
  logic [COUNTER_FEATURE_WIDTH-1:0]   coo_dst;
  logic                               prod_read_en;
  logic [COUNTER_FEATURE_WIDTH-1:0]   prod_read_addr;
  logic [WEIGHT_COLS*DOT_WIDTH-1:0]   prod_row_data;
  logic                               out_valid;
  logic                               out_ready;
  logic [COUNTER_FEATURE_WIDTH-1:0]   out_row_addr;
  logic [WEIGHT_COLS*DOT_WIDTH-1:0]   out_row_data;

  modport master (
    input  start, coo_src, coo_dst, prod_row_data, out_ready,
    output busy, done, err, coo_read_en, coo_read_addr, prod_read_en, prod_read_addr,
           out_valid, out_row_addr, out_row_data
  );

  modport slave (
    output start, coo_src, coo_dst, prod_row_data, out_ready,
    input  busy, done, err, coo_read_en, coo_read_addr, prod_read_en, prod_read_addr,
           out_valid, out_row_addr, out_row_data
  );
endinterface

// File: rtl/combination_fsm.sv
// Aggregates product rows along a COO edge list (out[dst] += prod[src]) and then
// streams the aggregated rows out over a valid/ready handshake.
module combination_fsm #(
  parameter int unsigned FEATURE_ROWS          = 6,
  parameter int unsigned WEIGHT_COLS           = 3,
  parameter int unsigned NUM_EDGES             = 6,
  parameter int unsigned DOT_WIDTH             = 16,
  parameter int unsigned COUNTER_EDGE_WIDTH    = $clog2(NUM_EDGES),
  parameter int unsigned COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS)
) (
  input  logic          clk,
  input  logic          reset,
  combination_if.master bus
);

  localparam int unsigned RowWidth = WEIGHT_COLS * DOT_WIDTH;
  localparam logic [COUNTER_EDGE_WIDTH-1:0]    LastEdge = COUNTER_EDGE_WIDTH'(NUM_EDGES - 1);
  localparam logic [COUNTER_FEATURE_WIDTH-1:0] LastRow  = COUNTER_FEATURE_WIDTH'(FEATURE_ROWS - 1);
  localparam logic [COUNTER_FEATURE_WIDTH:0]   RowsExt  = (COUNTER_FEATURE_WIDTH + 1)'(FEATURE_ROWS);

  typedef enum logic [2:0] {
    StIdle, StClear, StReadCoo, StReadProd, StAccum, StStream, StDone
  } state_e;

  state_e state_q, state_d;

  logic [COUNTER_EDGE_WIDTH-1:0]    edge_count_q;
  logic [COUNTER_FEATURE_WIDTH-1:0] row_count_q;
  logic [COUNTER_FEATURE_WIDTH-1:0] dst_q;
  logic                             skip_q;
  logic                             err_q;
  logic                             out_valid_q;
  logic [COUNTER_FEATURE_WIDTH-1:0] out_row_addr_q;
  logic [RowWidth-1:0]              out_row_data_q;

  logic [DOT_WIDTH-1:0] row_buf_q [FEATURE_ROWS][WEIGHT_COLS];

  logic                             edge_bad;
  logic                             last_accept;
  logic [COUNTER_FEATURE_WIDTH-1:0] sel_row;
  logic [RowWidth-1:0]              sel_data;

  assign edge_bad = ({1'b0, bus.coo_src} >= RowsExt) || ({1'b0, bus.coo_dst} >= RowsExt);
  assign last_accept = out_valid_q && bus.out_ready && (row_count_q == LastRow);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    bus.coo_read_en  = 1'b0;
    bus.prod_read_en = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) state_d = StClear;
      end
      StClear: state_d = StReadCoo;
      StReadCoo: begin
        bus.coo_read_en = 1'b1;
        state_d         = StReadProd;
      end
      StReadProd: begin
        bus.prod_read_en = !edge_bad;
        state_d          = StAccum;
      end
      StAccum: begin
        state_d = (edge_count_q == LastEdge) ? StStream : StReadCoo;
      end
      StStream: begin
        if (last_accept) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.coo_read_addr  = edge_count_q;
  assign bus.prod_read_addr = (state_q == StReadProd) ? bus.coo_src : '0;
  assign bus.busy           = (state_q != StIdle) && (state_q != StDone);
  assign bus.done           = (state_q == StDone);
  assign bus.err            = err_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_row_addr   = out_row_addr_q;
  assign bus.out_row_data   = out_row_data_q;

  // Row to present next: the current one while loading, else its successor.
  always_comb begin
    sel_row = row_count_q;
    if (out_valid_q && (row_count_q != LastRow)) sel_row = row_count_q + 1'b1;
    sel_data = '0;
    for (int unsigned c = 0; c < WEIGHT_COLS; c++) begin
      sel_data[c*DOT_WIDTH +: DOT_WIDTH] = row_buf_q[sel_row][c];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_count_q   <= '0;
      row_count_q    <= '0;
      dst_q          <= '0;
      skip_q         <= 1'b0;
      err_q          <= 1'b0;
      out_valid_q    <= 1'b0;
      out_row_addr_q <= '0;
      out_row_data_q <= '0;
    end else begin
      unique case (state_q)
        StClear: begin
          edge_count_q <= '0;
          row_count_q  <= '0;
          err_q        <= 1'b0;
          out_valid_q  <= 1'b0;
        end
        StReadProd: begin
          dst_q  <= bus.coo_dst;
          skip_q <= edge_bad;
          if (edge_bad) err_q <= 1'b1;
        end
        StAccum: begin
          if (edge_count_q == LastEdge) begin
            row_count_q <= '0;
          end else begin
            edge_count_q <= edge_count_q + 1'b1;
          end
        end
        StStream: begin
          // Output row is registered: one load cycle, then back-to-back rows on handshake.
          if (!out_valid_q) begin
            out_valid_q    <= 1'b1;
            out_row_addr_q <= sel_row;
            out_row_data_q <= sel_data;
          end else if (bus.out_ready) begin
            if (row_count_q == LastRow) begin
              out_valid_q <= 1'b0;
            end else begin
              row_count_q    <= sel_row;
              out_row_addr_q <= sel_row;
              out_row_data_q <= sel_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Buffer contents are don't-care until CLEAR, so no reset.
  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      for (int unsigned r = 0; r < FEATURE_ROWS; r++) begin
        for (int unsigned c = 0; c < WEIGHT_COLS; c++) begin
          row_buf_q[r][c] <= '0;
        end
      end
    end else if ((state_q == StAccum) && !skip_q) begin
      for (int unsigned c = 0; c < WEIGHT_COLS; c++) begin
        row_buf_q[dst_q][c] <= row_buf_q[dst_q][c] + bus.prod_row_data[c*DOT_WIDTH +: DOT_WIDTH];
      end
    end
  end

endmodule
